regfile_debug_arbiter: RTL and testbench
========================================

# regfile_debug_arbiter

Shares the single regfile between the processor and a debug/test master through a request/acknowledge handshake, replacing the static test-select mux in the test wrapper. The processor owns the regfile by default. A debug request stalls the processor, waits for a programmable drain interval, performs one read or write on the regfile, and returns the result. The block sits between the processor's regfile ports and the regfile instance.

## Interface
- STALL_CYCLES, 2: cycles spent in DRAIN (processor stalled, no regfile access) before debug access; legal 1..15
- clock  in  1  single system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- p_ctrl_writeEnable  in  1  processor write enable
- p_ctrl_writeReg  in  5  processor write address
- p_ctrl_readRegA, p_ctrl_readRegB  in  5 each  processor read addresses
- p_data_writeReg  in  32  processor write data
- p_stall  out  1  freeze processor PC/pipeline while high
- d_req  in  1  debug request; held high until d_ack
- d_we  in  1  1 = write, 0 = read; sampled with d_req
- d_addr  in  5  debug register index
- d_wdata  in  32  debug write data
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  32  registered read result; valid from d_ack until next completed read
- r_ctrl_writeEnable  out  1  to regfile
- r_ctrl_writeReg, r_ctrl_readRegA, r_ctrl_readRegB  out  5 each  to regfile
- r_data_writeReg  out  32  to regfile
- r_data_readRegA  in  32  regfile port A read data (combinational read)

## Operation
- FSM states: IDLE, DRAIN, ACCESS, DONE.
- IDLE: r_* outputs pass p_* through; p_stall=0. d_req=1 and p_ctrl_writeEnable=0 -> capture d_we/d_addr/d_wdata, go DRAIN. d_req=1 while processor writes -> stay IDLE (processor priority; its write completes untouched).
- DRAIN: p_stall=1; r_ctrl_writeEnable forced 0; read addresses still pass through. Down-counter loaded with STALL_CYCLES-1 on entry; at 0 -> ACCESS.
- ACCESS (1 cycle): p_stall=1; regfile driven from captured request. Write: r_ctrl_writeEnable=1, writeReg=addr, data=wdata; write to addr 0 is suppressed (enable 0) but still acknowledged. Read: r_ctrl_readRegA=addr, enable 0; r_data_readRegA registered into d_rdata at the end of the cycle. Next state DONE.
- DONE: d_ack=1 for exactly this cycle; p_stall=1; r_* pass p_* with writeEnable forced 0. Next state IDLE, where p_stall drops.
- Debug inputs are sampled only on the IDLE->DRAIN transition; later changes are ignored. d_req deassertion before ack does not abort the access.
- d_req still high in IDLE after DONE starts a new transaction; the master lowers d_req on the d_ack cycle to avoid this.

## Timing
- Reset values: state IDLE, p_stall 0, d_ack 0, d_rdata 0, counter 0; r_* pass-through from the cycle after reset.
- Reset in any state aborts the access; no regfile write is issued in the reset cycle.
- Request-to-ack latency: STALL_CYCLES+2 cycles after the accepting edge, counting from IDLE with no processor write.
- p_stall is high for STALL_CYCLES+2 cycles per transaction.
- p_stall, d_ack and state are registered. r_* muxing is combinational from state and captured registers.

## Structure
- Package regfile_arb_pkg holds the state enum (2-bit encoding IDLE=0, DRAIN=1, ACCESS=2, DONE=3) and the register-zero constant.
- One sub-module, regfile_port_mux: combinational selection of r_* between processor and captured debug fields, with the write-enable forcing. The FSM, counter and capture registers live in the top module.

## Test plan
- Idle pass-through: p_ctrl_writeEnable=1, writeReg=5, data=0x1234, no d_req -> r_* mirror p_* every cycle; p_stall stays 0.
- Debug write: d_req=1, d_we=1, addr=7, wdata=0xDEADBEEF, STALL_CYCLES=2 -> p_stall high 4 cycles; regfile write of reg 7 in the ACCESS cycle; d_ack at the 4th cycle; readback of reg 7 returns 0xDEADBEEF.
- Debug read: reg 3 preloaded with 0xA5A5A5A5; d_req read of addr 3 -> d_rdata=0xA5A5A5A5 on the d_ack cycle, held until the next read.
- Processor priority: d_req rises on a cycle with p_ctrl_writeEnable=1 -> processor write to reg 9 lands; DRAIN is entered only on the first cycle with writeEnable=0.
- Register zero: debug write of 0xFFFFFFFF to addr 0 -> r_ctrl_writeEnable stays 0; d_ack still pulses; reg 0 reads 0.
- Reset mid-access: assert reset during DRAIN -> next cycle state IDLE, p_stall=0, no d_ack and no regfile write.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the regfile debug arbiter.
// State encoding is fixed so debug tooling can decode a captured state value.
package regfile_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRAIN  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } arb_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam int         CNT_W    = 4;

endpackage

// File: rtl/regfile_port_mux.sv
// Combinational steering of the regfile ports between the processor and the
// captured debug request, including write-enable forcing.
module regfile_port_mux
   import regfile_arb_pkg::*;
(
   input  logic        allow_p_we,
   input  logic        debug_sel,
   input  logic        cap_we,
   input  logic [4:0]  cap_addr,
   input  logic [31:0] cap_wdata,
   input  logic        p_ctrl_writeEnable,
   input  logic [4:0]  p_ctrl_writeReg,
   input  logic [4:0]  p_ctrl_readRegA,
   input  logic [4:0]  p_ctrl_readRegB,
   input  logic [31:0] p_data_writeReg,
   output logic        r_ctrl_writeEnable,
   output logic [4:0]  r_ctrl_writeReg,
   output logic [4:0]  r_ctrl_readRegA,
   output logic [4:0]  r_ctrl_readRegB,
   output logic [31:0] r_data_writeReg
);

   always_comb begin
      r_ctrl_writeEnable = p_ctrl_writeEnable & allow_p_we;
      r_ctrl_writeReg    = p_ctrl_writeReg;
      r_ctrl_readRegA    = p_ctrl_readRegA;
      r_ctrl_readRegB    = p_ctrl_readRegB;
      r_data_writeReg    = p_data_writeReg;
      if (debug_sel) begin
         if (cap_we) begin
            // Register zero is hardwired; the access is still acknowledged upstream.
            r_ctrl_writeEnable = (cap_addr != REG_ZERO);
            r_ctrl_writeReg    = cap_addr;
            r_data_writeReg    = cap_wdata;
         end else begin
            r_ctrl_writeEnable = 1'b0;
            r_ctrl_readRegA    = cap_addr;
         end
      end
   end

endmodule

// File: rtl/regfile_debug_arbiter.sv
// Arbitrates the single regfile between the processor and a debug master:
// a debug request stalls the processor, drains, does one access, then acks.
//
//  state  | meaning
//  IDLE   | processor owns regfile, waiting for debug request
//  DRAIN  | processor stalled, writes blocked, counting down the drain interval
//  ACCESS | captured debug read or write drives the regfile for one cycle
//  DONE   | d_ack pulse, processor still stalled, writes blocked
module regfile_debug_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int STALL_CYCLES = 2
)
(
   input  logic        clock,
   input  logic        reset,
   input  logic        p_ctrl_writeEnable,
   input  logic [4:0]  p_ctrl_writeReg,
   input  logic [4:0]  p_ctrl_readRegA,
   input  logic [4:0]  p_ctrl_readRegB,
   input  logic [31:0] p_data_writeReg,
   output logic        p_stall,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [4:0]  d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        r_ctrl_writeEnable,
   output logic [4:0]  r_ctrl_writeReg,
   output logic [4:0]  r_ctrl_readRegA,
   output logic [4:0]  r_ctrl_readRegB,
   output logic [31:0] r_data_writeReg,
   input  logic [31:0] r_data_readRegA
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STALL_CYCLES - 1);

   arb_state_t        state;
   arb_state_t        state_next;
   logic [CNT_W-1:0]  cnt;
   logic              cap_we;
   logic [4:0]        cap_addr;
   logic [31:0]       cap_wdata;
   logic              accept;
   logic              allow_p_we;
   logic              debug_sel;

   // An in-flight processor write always wins over a new debug request.
   assign accept = (state == IDLE) && d_req && !p_ctrl_writeEnable;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = DRAIN;
         DRAIN:   if (cnt == '0) state_next = ACCESS;
         ACCESS:  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         p_stall   <= 1'b0;
         d_ack     <= 1'b0;
         d_rdata   <= '0;
         cap_we    <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
      end else begin
         state   <= state_next;
         p_stall <= (state_next != IDLE);
         d_ack   <= (state_next == DONE);
         if (accept) begin
            cnt       <= CNT_LOAD;
            cap_we    <= d_we;
            cap_addr  <= d_addr;
            cap_wdata <= d_wdata;
         end else if (state == DRAIN && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (state == ACCESS && !cap_we) begin
            d_rdata <= r_data_readRegA;
         end
      end
   end

   // Gating with reset keeps the reset cycle free of regfile writes.
   assign allow_p_we = (state == IDLE) && !reset;
   assign debug_sel  = (state == ACCESS) && !reset;

   regfile_port_mux u_port_mux (
      .allow_p_we         (allow_p_we),
      .debug_sel          (debug_sel),
      .cap_we             (cap_we),
      .cap_addr           (cap_addr),
      .cap_wdata          (cap_wdata),
      .p_ctrl_writeEnable (p_ctrl_writeEnable),
      .p_ctrl_writeReg    (p_ctrl_writeReg),
      .p_ctrl_readRegA    (p_ctrl_readRegA),
      .p_ctrl_readRegB    (p_ctrl_readRegB),
      .p_data_writeReg    (p_data_writeReg),
      .r_ctrl_writeEnable (r_ctrl_writeEnable),
      .r_ctrl_writeReg    (r_ctrl_writeReg),
      .r_ctrl_readRegA    (r_ctrl_readRegA),
      .r_ctrl_readRegB    (r_ctrl_readRegB),
      .r_data_writeReg    (r_data_writeReg)
   );

endmodule

// File: tb/tb_regfile_debug_arbiter.sv
// Bench for regfile_debug_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model with its own regfile image.
module tb_regfile_debug_arbiter;

   localparam int S = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        p_ctrl_writeEnable;
   logic [4:0]  p_ctrl_writeReg;
   logic [4:0]  p_ctrl_readRegA;
   logic [4:0]  p_ctrl_readRegB;
   logic [31:0] p_data_writeReg;
   logic        p_stall;
   logic        d_req;
   logic        d_we;
   logic [4:0]  d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        r_ctrl_writeEnable;
   logic [4:0]  r_ctrl_writeReg;
   logic [4:0]  r_ctrl_readRegA;
   logic [4:0]  r_ctrl_readRegB;
   logic [31:0] r_data_writeReg;
   logic [31:0] r_data_readRegA;

   always #5 clock = ~clock;

   regfile_debug_arbiter #(.STALL_CYCLES(S)) dut (
      .clock              (clock),
      .reset              (reset),
      .p_ctrl_writeEnable (p_ctrl_writeEnable),
      .p_ctrl_writeReg    (p_ctrl_writeReg),
      .p_ctrl_readRegA    (p_ctrl_readRegA),
      .p_ctrl_readRegB    (p_ctrl_readRegB),
      .p_data_writeReg    (p_data_writeReg),
      .p_stall            (p_stall),
      .d_req              (d_req),
      .d_we               (d_we),
      .d_addr             (d_addr),
      .d_wdata            (d_wdata),
      .d_ack              (d_ack),
      .d_rdata            (d_rdata),
      .r_ctrl_writeEnable (r_ctrl_writeEnable),
      .r_ctrl_writeReg    (r_ctrl_writeReg),
      .r_ctrl_readRegA    (r_ctrl_readRegA),
      .r_ctrl_readRegB    (r_ctrl_readRegB),
      .r_data_writeReg    (r_data_writeReg),
      .r_data_readRegA    (r_data_readRegA)
   );

   // rf is the physical regfile the DUT drives; ref_rf is the model's view.
   logic [31:0] rf     [32];
   logic [31:0] ref_rf [32];
   assign r_data_readRegA = rf[r_ctrl_readRegA];

   int          errors = 0;
   int          checks = 0;
   int          busy   = 0;
   logic        c_we;
   logic [4:0]  c_addr;
   logic [31:0] c_wdata;
   logic [31:0] m_rdata = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: check outputs at negedge, advance the model, apply regfile write.
   task automatic cycle();
      int          ph;
      logic        wr;
      logic [4:0]  wa;
      logic [31:0] wd;
      @(negedge clock);
      wr = r_ctrl_writeEnable;
      wa = r_ctrl_writeReg;
      wd = r_data_writeReg;
      if (reset) begin
         chk("rst_no_write", 32'(r_ctrl_writeEnable), 32'd0);
         busy    = 0;
         m_rdata = '0;
      end else if (busy == 0) begin
         chk("idle_stall", 32'(p_stall), 32'd0);
         chk("idle_ack", 32'(d_ack), 32'd0);
         chk("idle_rdata", d_rdata, m_rdata);
         chk("idle_we", 32'(r_ctrl_writeEnable), 32'(p_ctrl_writeEnable));
         chk("idle_wreg", 32'(r_ctrl_writeReg), 32'(p_ctrl_writeReg));
         chk("idle_wdata", r_data_writeReg, p_data_writeReg);
         chk("idle_ra", 32'(r_ctrl_readRegA), 32'(p_ctrl_readRegA));
         chk("idle_rb", 32'(r_ctrl_readRegB), 32'(p_ctrl_readRegB));
         if (p_ctrl_writeEnable) begin
            ref_rf[p_ctrl_writeReg] = p_data_writeReg;
         end else if (d_req) begin
            busy    = S + 2;
            c_we    = d_we;
            c_addr  = d_addr;
            c_wdata = d_wdata;
         end
      end else begin
         ph = S + 3 - busy;
         chk("busy_stall", 32'(p_stall), 32'd1);
         chk("busy_ack", 32'(d_ack), 32'(ph == S + 2));
         chk("busy_rdata", d_rdata, m_rdata);
         chk("busy_rb", 32'(r_ctrl_readRegB), 32'(p_ctrl_readRegB));
         if (ph == S + 1) begin
            if (c_we) begin
               chk("acc_we", 32'(r_ctrl_writeEnable), 32'(c_addr != 5'd0));
               if (c_addr != 5'd0) begin
                  chk("acc_wreg", 32'(r_ctrl_writeReg), 32'(c_addr));
                  chk("acc_wdata", r_data_writeReg, c_wdata);
                  ref_rf[c_addr] = c_wdata;
               end
            end else begin
               chk("acc_rd_we", 32'(r_ctrl_writeEnable), 32'd0);
               chk("acc_ra", 32'(r_ctrl_readRegA), 32'(c_addr));
               m_rdata = ref_rf[c_addr];
            end
         end else begin
            chk("stall_we", 32'(r_ctrl_writeEnable), 32'd0);
            chk("stall_ra", 32'(r_ctrl_readRegA), 32'(p_ctrl_readRegA));
         end
         busy--;
      end
      @(posedge clock);
      #1;
      if (wr === 1'b1) rf[wa] = wd;
   endtask

   task automatic dbg_txn(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                          output int stall_cnt, output int ack_at, output logic [31:0] rdata_ack);
      p_ctrl_writeEnable = 1'b0;
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = addr;
      d_wdata = wdata;
      stall_cnt = 0;
      ack_at    = 0;
      rdata_ack = '0;
      cycle();
      for (int i = 1; i <= S + 6; i++) begin
         if (p_stall) stall_cnt++;
         if (d_ack && ack_at == 0) begin
            ack_at    = i;
            rdata_ack = d_rdata;
            d_req     = 1'b0;
         end
         cycle();
      end
      d_req = 1'b0;
   endtask

   initial begin
      int          sc;
      int          aa;
      logic [31:0] rd;
      logic [31:0] old;
      logic        seen;

      reset = 1'b1;
      p_ctrl_writeEnable = 1'b0;
      p_ctrl_writeReg    = '0;
      p_ctrl_readRegA    = '0;
      p_ctrl_readRegB    = '0;
      p_data_writeReg    = '0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_addr  = '0;
      d_wdata = '0;
      for (int i = 0; i < 32; i++) begin
         rf[i]     = (i == 0) ? 32'd0 : $urandom;
         ref_rf[i] = rf[i];
      end
      #1;
      cycle();
      cycle();
      reset = 1'b0;
      chk("rst_stall", 32'(p_stall), 32'd0);
      chk("rst_ack", 32'(d_ack), 32'd0);
      chk("rst_rdata", d_rdata, 32'd0);

      // Idle pass-through
      p_ctrl_writeEnable = 1'b1;
      p_ctrl_writeReg    = 5'd5;
      p_data_writeReg    = 32'h0000_1234;
      for (int i = 0; i < 4; i++) begin
         p_ctrl_readRegA = 5'($urandom);
         p_ctrl_readRegB = 5'($urandom);
         cycle();
      end
      p_ctrl_writeEnable = 1'b0;
      chk("pass_rf5", rf[5], 32'h0000_1234);

      // Debug write and readback
      dbg_txn(1'b1, 5'd7, 32'hDEAD_BEEF, sc, aa, rd);
      chk("wr_stall_cycles", 32'(sc), 32'(S + 2));
      chk("wr_ack_at", 32'(aa), 32'(S + 2));
      chk("wr_rf7", rf[7], 32'hDEAD_BEEF);
      dbg_txn(1'b0, 5'd7, 32'd0, sc, aa, rd);
      chk("wr_readback", rd, 32'hDEAD_BEEF);

      // Debug read of a preloaded register, then hold across a write
      p_ctrl_writeEnable = 1'b1;
      p_ctrl_writeReg    = 5'd3;
      p_data_writeReg    = 32'hA5A5_A5A5;
      cycle();
      p_ctrl_writeEnable = 1'b0;
      dbg_txn(1'b0, 5'd3, 32'd0, sc, aa, rd);
      chk("rd_ack_at", 32'(aa), 32'(S + 2));
      chk("rd_data_at_ack", rd, 32'hA5A5_A5A5);
      dbg_txn(1'b1, 5'd4, 32'h0BAD_F00D, sc, aa, rd);
      chk("rd_hold", d_rdata, 32'hA5A5_A5A5);

      // Processor priority
      p_ctrl_writeEnable = 1'b1;
      p_ctrl_writeReg    = 5'd9;
      p_data_writeReg    = 32'h9999_0009;
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 5'd9;
      cycle();
      chk("prio_no_stall0", 32'(p_stall), 32'd0);
      cycle();
      chk("prio_no_stall1", 32'(p_stall), 32'd0);
      chk("prio_rf9", rf[9], 32'h9999_0009);
      p_ctrl_writeEnable = 1'b0;
      cycle();
      chk("prio_drain", 32'(p_stall), 32'd1);
      aa = 0;
      rd = '0;
      for (int i = 0; i < S + 6; i++) begin
         if (d_ack && aa == 0) begin
            aa    = 1;
            rd    = d_rdata;
            d_req = 1'b0;
         end
         cycle();
      end
      d_req = 1'b0;
      chk("prio_ack_seen", 32'(aa), 32'd1);
      chk("prio_rdata", rd, 32'h9999_0009);

      // Register zero
      dbg_txn(1'b1, 5'd0, 32'hFFFF_FFFF, sc, aa, rd);
      chk("r0_ack_at", 32'(aa), 32'(S + 2));
      chk("r0_value", rf[0], 32'd0);

      // Reset during DRAIN
      old     = rf[12];
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 5'd12;
      d_wdata = ~old;
      cycle();
      chk("rm_in_drain", 32'(p_stall), 32'd1);
      reset = 1'b1;
      d_req = 1'b0;
      cycle();
      reset = 1'b0;
      chk("rm_stall", 32'(p_stall), 32'd0);
      chk("rm_ack", 32'(d_ack), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < S + 4; i++) begin
         seen = seen | d_ack;
         cycle();
      end
      chk("rm_no_ack", 32'(seen), 32'd0);
      chk("rm_rf12", rf[12], old);

      // Random traffic
      for (int n = 0; n < 1500; n++) begin
         p_ctrl_writeEnable = ($urandom_range(0, 2) == 0);
         p_ctrl_writeReg    = 5'($urandom_range(1, 31));
         p_ctrl_readRegA    = 5'($urandom);
         p_ctrl_readRegB    = 5'($urandom);
         p_data_writeReg    = $urandom;
         if (d_req) begin
            if (d_ack) d_req = ($urandom_range(0, 3) == 0);
            else if ($urandom_range(0, 15) == 0) d_req = 1'b0;
         end else if ($urandom_range(0, 3) == 0) begin
            d_req = 1'b1;
         end
         d_we    = 1'($urandom_range(0, 1));
         d_addr  = 5'($urandom);
         d_wdata = $urandom;
         reset   = ($urandom_range(0, 199) == 0);
         cycle();
      end
      reset = 1'b0;
      d_req = 1'b0;
      p_ctrl_writeEnable = 1'b0;
      repeat (S + 4) cycle();
      for (int i = 0; i < 32; i++) begin
         chk($sformatf("final_rf%0d", i), rf[i], ref_rf[i]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
